// File: rtl/fp_pkg.sv
// Shared floating-point types and width-parametrised constants for the FPU datapath.
package fp_pkg;

  typedef enum logic {
    RM_RNE = 1'b0,
    RM_RTZ = 1'b1
  } rm_e;

  typedef enum logic [2:0] {
    ZERO,
    NORM,
    INF,
    QNAN,
    SNAN
  } fp_class_e;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
  } fp_flags_t;

  // Exponent bias for a given exponent field width.
  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, only the fraction MSB set.
  function automatic logic [63:0] fp_canon_nan(input int exp_w, input int man_w);
    return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
  endfunction

  // Largest finite magnitude: exponent all-ones-minus-one, fraction all ones.
  function automatic logic [63:0] fp_max_finite(input int exp_w, input int man_w);
    return (((64'd1 << exp_w) - 64'd2) << man_w) | ((64'd1 << man_w) - 64'd1);
  endfunction

endpackage

// File: rtl/fp_norm_round.sv
// Normalise, round, and pack a raw mantissa product with overflow saturation and flush-to-zero.
module fp_norm_round
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     sign,
  input  logic signed [EXP_W+1:0]  exp_in,
  input  logic [2*MAN_W+1:0]       prod,
  input  rm_e                      rm,
  output logic [EXP_W+MAN_W:0]     res,
  output fp_flags_t                flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int EW = EXP_W + 2;
  localparam int PW = 2 * MAN_W + 2;
  localparam logic signed [EW-1:0] EXP_LIMIT = EW'((1 << EXP_W) - 1);
  localparam logic [W-1:0] MAX_FIN = W'(fp_max_finite(EXP_W, MAN_W));

  logic                 top;
  logic [PW-1:0]        norm;
  logic [MAN_W:0]       mant;
  logic                 guard;
  logic                 sticky;
  logic                 inc;
  logic [MAN_W+1:0]     mant_r;
  logic                 carry;
  logic [MAN_W-1:0]     frac;
  logic signed [EW-1:0] exp_fin;

  // Product lies in [1,4); bring it into [1,2), round, then saturate or flush the exponent.
  always_comb begin
    top     = prod[PW-1];
    norm    = top ? {1'b0, prod[PW-1:1]} : prod;
    mant    = norm[PW-2:MAN_W];
    guard   = norm[MAN_W-1];
    sticky  = (|norm[MAN_W-2:0]) | (top & prod[0]);
    inc     = (rm == RM_RNE) & guard & (sticky | mant[0]);
    mant_r  = {1'b0, mant} + (MAN_W+2)'(inc);
    carry   = mant_r[MAN_W+1];
    frac    = carry ? '0 : mant_r[MAN_W-1:0];
    exp_fin = exp_in + EW'(top) + EW'(carry);

    flags         = '0;
    flags.inexact = guard | sticky;
    res           = {sign, exp_fin[EXP_W-1:0], frac};

    if (exp_fin >= EXP_LIMIT) begin
      flags.overflow = 1'b1;
      flags.inexact  = 1'b1;
      if (rm == RM_RNE) res = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      else              res = {sign, MAX_FIN[W-2:0]};
    end else if (exp_fin <= 0) begin
      flags.underflow = 1'b1;
      flags.inexact   = |prod;
      res             = {sign, {(W-1){1'b0}}};
    end
  end

endmodule

// File: rtl/fp_mult_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready flow control and a global stall.
module fp_mult_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     in_a,
  input  logic [EXP_W+MAN_W:0]     in_b,
  input  logic                     in_rm,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     out_res,
  output logic [3:0]               out_flags,
  output logic [TAG_W-1:0]         out_tag
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int EW   = EXP_W + 2;
  localparam int PW   = 2 * MAN_W + 2;
  localparam int BIAS = fp_bias(EXP_W);
  localparam logic [W-1:0] CANON_NAN = W'(fp_canon_nan(EXP_W, MAN_W));

  function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
    fp_class_e c;
    c = NORM;
    if (e == '0) c = ZERO;
    else if (e == '1) begin
      if (f == '0)         c = INF;
      else if (f[MAN_W-1]) c = QNAN;
      else                 c = SNAN;
    end
    return c;
  endfunction

  logic                 sa, sb;
  logic [EXP_W-1:0]     ea, eb;
  logic [MAN_W-1:0]     fa, fb;
  fp_class_e            ca, cb;
  logic                 adv;

  logic                 sp_special;
  logic [W-1:0]         sp_res;
  fp_flags_t            sp_flags;
  logic signed [EW-1:0] exp_sum;

  logic                 s1_valid, s1_special, s1_sign;
  rm_e                  s1_rm;
  logic [TAG_W-1:0]     s1_tag;
  logic [W-1:0]         s1_res;
  fp_flags_t            s1_flags;
  logic signed [EW-1:0] s1_exp;
  logic [MAN_W:0]       s1_man_a, s1_man_b;

  logic                 s2_valid, s2_special, s2_sign;
  rm_e                  s2_rm;
  logic [TAG_W-1:0]     s2_tag;
  logic [W-1:0]         s2_res;
  fp_flags_t            s2_flags;
  logic signed [EW-1:0] s2_exp;
  logic [PW-1:0]        s2_prod;

  logic [W-1:0]         nr_res;
  fp_flags_t            nr_flags;

  assign {sa, ea, fa} = in_a;
  assign {sb, eb, fb} = in_b;
  assign ca = classify(ea, fa);
  assign cb = classify(eb, fb);

  // The whole pipe advances together; only the output consumer can stall it.
  assign in_ready = !out_valid | out_ready;
  assign adv      = in_ready;

  assign exp_sum = {2'b00, ea} + {2'b00, eb} - EW'(BIAS);

  // Resolve NaN/inf/zero operands up front so later stages only forward the answer.
  always_comb begin
    sp_special = 1'b1;
    sp_res     = '0;
    sp_flags   = '0;
    if (ca == QNAN || ca == SNAN || cb == QNAN || cb == SNAN) begin
      sp_res           = CANON_NAN;
      sp_flags.invalid = (ca == SNAN) || (cb == SNAN);
    end else if ((ca == INF && cb == ZERO) || (ca == ZERO && cb == INF)) begin
      sp_res           = CANON_NAN;
      sp_flags.invalid = 1'b1;
    end else if (ca == INF || cb == INF) begin
      sp_res = {sa ^ sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (ca == ZERO || cb == ZERO) begin
      sp_res = {sa ^ sb, {(W-1){1'b0}}};
    end else begin
      sp_special = 1'b0;
    end
  end

  // Stage 1: classification result, biased exponent sum and mantissas with hidden bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_special <= 1'b0;
      s1_sign    <= 1'b0;
      s1_rm      <= RM_RNE;
      s1_tag     <= '0;
      s1_res     <= '0;
      s1_flags   <= '0;
      s1_exp     <= '0;
      s1_man_a   <= '0;
      s1_man_b   <= '0;
    end else if (adv) begin
      s1_valid   <= in_valid;
      s1_special <= sp_special;
      s1_sign    <= sa ^ sb;
      s1_rm      <= rm_e'(in_rm);
      s1_tag     <= in_tag;
      s1_res     <= sp_res;
      s1_flags   <= sp_flags;
      s1_exp     <= exp_sum;
      s1_man_a   <= {1'b1, fa};
      s1_man_b   <= {1'b1, fb};
    end
  end

  // Stage 2: full-width mantissa product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid   <= 1'b0;
      s2_special <= 1'b0;
      s2_sign    <= 1'b0;
      s2_rm      <= RM_RNE;
      s2_tag     <= '0;
      s2_res     <= '0;
      s2_flags   <= '0;
      s2_exp     <= '0;
      s2_prod    <= '0;
    end else if (adv) begin
      s2_valid   <= s1_valid;
      s2_special <= s1_special;
      s2_sign    <= s1_sign;
      s2_rm      <= s1_rm;
      s2_tag     <= s1_tag;
      s2_res     <= s1_res;
      s2_flags   <= s1_flags;
      s2_exp     <= s1_exp;
      s2_prod    <= s1_man_a * s1_man_b;
    end
  end

  fp_norm_round #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_norm_round (
    .sign   (s2_sign),
    .exp_in (s2_exp),
    .prod   (s2_prod),
    .rm     (s2_rm),
    .res    (nr_res),
    .flags  (nr_flags)
  );

  // Stage 3: pick special or rounded result; these registers drive the outputs directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_res   <= '0;
      out_flags <= '0;
      out_tag   <= '0;
    end else if (adv) begin
      out_valid <= s2_valid;
      out_res   <= s2_special ? s2_res : nr_res;
      out_flags <= s2_special ? s2_flags : nr_flags;
      out_tag   <= s2_tag;
    end
  end

endmodule
